sqrt_responder: RTL
===================

Name: sqrt_responder

Overview:
- Hardware responder for the program-3 launch protocol.
- The host bench plays initiator: it preloads a 16-bit operand into data memory at bytes 16 (MSB) and 17 (LSB), pulses Start, waits for Ack, then reads byte 18.
- This block is the other end of that exchange. It detects the launch, reads the operand over a byte-wide data-memory port, computes the integer square root, writes it back and raises Ack.
- It drops into CPU-level benches in place of a software sqrt program, as the golden hardware model and as an accelerator.

Parameters:
- AW, 8, data-memory address width.
- ADDR_HI, 16, address of operand MSB.
- ADDR_LO, 17, address of operand LSB.
- ADDR_RES, 18, address of 8-bit result.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  launch request from initiator.
- Ack  out  1  run complete; held until next launch.
- MemAddr  out  AW  data-memory byte address.
- MemRdData  in  8  data-memory read data, combinational (same-cycle) read.
- MemWrEn  out  1  data-memory write strobe; write occurs at the rising edge while high.
- MemWrData  out  8  data-memory write data.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high: sampled on the Clk rising edge; while high, FSM goes to IDLE.
- Reset values: Ack=0, MemWrEn=0, MemAddr=0, MemWrData=0; root=0; rem=0; iteration count=0.
- Launch rule: a run starts on the Start falling edge, i.e. Start sampled 1 then sampled 0.
  - Start held high only arms the block.
  - A Start pulse of any length of at least 1 cycle is valid.
  - A Start already high when Reset releases arms the block normally.
- FSM states and transitions:
  - IDLE: Start=1 -> ARMED.
  - ARMED: Start=0 -> RD_HI.
  - RD_HI: MemAddr=ADDR_HI; latch MemRdData into op[15:8] -> RD_LO.
  - RD_LO: MemAddr=ADDR_LO; latch op[7:0] -> CALC.
  - CALC: 8 cycles, one restoring digit-by-digit iteration per cycle, MSB pair first.
    - rem = {rem, op[2k+1:2k]}; trial = {root, 2'b01}.
    - If rem >= trial: rem -= trial and root = {root,1}; else root = {root,0}.
    - rem is 11 bits, root is 8 bits; no overflow possible.
    - After the 8th iteration -> WR.
  - WR: MemAddr=ADDR_RES, MemWrData=result, MemWrEn=1 for exactly one cycle -> DONE.
  - DONE: Ack=1 (registered, first high the cycle after WR). Start=1 -> Ack=0 next cycle and go to ARMED.
- Latency: Ack rises 12 cycles after the cycle where Start is first sampled low.
- Result: floor(sqrt(op)), range 0..255. op=0 -> 0, with no special path needed.
- Start changes during RD_HI..WR are ignored; no restart occurs mid-run.
- Reset mid-run: abort immediately to IDLE. No write is issued; MemWrEn is never high in the reset cycle or the cycle after.
- MemAddr is held at 0 in IDLE, ARMED and DONE. MemWrEn is high only in WR.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined: result is round-to-nearest.
  - With floor root r and final remainder rem = op - r², increment r if rem > r.
  - Saturate: if r == 255, no increment.
  - Rounding is applied in WR with no extra cycle; latency unchanged.
- Undefined: result is floor(sqrt(op)) exactly.

Decomposition:
- Shared package/include sqrt_pkg holds:
  - FSM state encodings (3-bit localparams IDLE..DONE);
  - default ADDR_HI/ADDR_LO/ADDR_RES constants;
  - CALC_ITERS=8.
- One natural sub-module: sqrt_step, combinational, one iteration.
  - Inputs: rem_in, root_in, bit pair.
  - Outputs: rem_out, root_out.
  - Instantiated once and reused across the 8 CALC cycles.

Test Plan:
- Perfect square: op=36864 (0x9000) -> byte18=0xC0; Ack rises 12 cycles after Start sampled low; exactly one MemWrEn pulse, at address 18.
- Extremes: op=0 -> 0x00; op=65535 -> 0xFF in both builds (the SQRT_ROUND_EN build saturates).
- Rounding boundary: op=65024 -> 0xFE without SQRT_ROUND_EN, 0xFF with it. op=2 -> 0x01 in both builds.
- Back-to-back runs: after Ack, raise Start with op=49 -> Ack drops the next cycle; lower Start -> byte18=0x07 and Ack returns.
- Reset mid-CALC: assert Reset in the 4th CALC cycle -> Ack=0, byte18 unchanged, no MemWrEn; a subsequent launch with op=100 -> 0x0A.
- Start held high for 10 cycles then low with op=255 -> no memory activity while Start is high; result 0x0F, or 0x10 under SQRT_ROUND_EN.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared FSM encoding, default memory map and datapath sizes for the
// program-3 square-root responder.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RD_HI = 3'd2,
        RD_LO = 3'd3,
        CALC  = 3'd4,
        WR    = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int DEF_ADDR_HI  = 16;
    localparam int DEF_ADDR_LO  = 17;
    localparam int DEF_ADDR_RES = 18;

    localparam int CALC_ITERS = 8;
    localparam int REM_W      = 11;
    localparam int ROOT_W     = 8;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings down the next
// operand bit pair and decides the next root bit.
module sqrt_step
    import sqrt_pkg::*;
(
    input  logic [REM_W-1:0]  rem_in,
    input  logic [ROOT_W-1:0] root_in,
    input  logic [1:0]        pair,
    output logic [REM_W-1:0]  rem_out,
    output logic [ROOT_W-1:0] root_out
);

    logic [REM_W+1:0] shifted;
    logic [REM_W+1:0] trial;

    // Compare at full width so no remainder bits are silently dropped.
    always_comb begin
        shifted = {rem_in, pair};
        trial   = {3'b000, root_in, 2'b01};
        if (shifted >= trial) begin
            rem_out  = REM_W'(shifted - trial);
            root_out = {root_in[ROOT_W-2:0], 1'b1};
        end else begin
            rem_out  = REM_W'(shifted);
            root_out = {root_in[ROOT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sqrt_responder.sv
// Program-3 launch-protocol responder: on a Start falling edge reads a 16-bit
// operand, writes its integer square root back and raises Ack. Define
// SQRT_ROUND_EN for a round-to-nearest result instead of floor.
module sqrt_responder
    import sqrt_pkg::*;
#(
    parameter int AW       = 8,
    parameter int ADDR_HI  = DEF_ADDR_HI,
    parameter int ADDR_LO  = DEF_ADDR_LO,
    parameter int ADDR_RES = DEF_ADDR_RES
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          Ack,
    output logic [AW-1:0] MemAddr,
    input  logic [7:0]    MemRdData,
    output logic          MemWrEn,
    output logic [7:0]    MemWrData
);

    state_t state;
    state_t next_state;

    logic [15:0]       op_q;
    logic [REM_W-1:0]  rem_q;
    logic [REM_W-1:0]  rem_nxt;
    logic [ROOT_W-1:0] root_q;
    logic [ROOT_W-1:0] root_nxt;
    logic [ROOT_W-1:0] result;
    logic [2:0]        iter_q;
    logic              last_iter;

    assign last_iter = (iter_q == 3'(CALC_ITERS - 1));

    // The operand register shifts left each CALC cycle, so the top pair is
    // always the next one to consume.
    sqrt_step u_step (
        .rem_in  (rem_q),
        .root_in (root_q),
        .pair    (op_q[15:14]),
        .rem_out (rem_nxt),
        .root_out(root_nxt)
    );

`ifdef SQRT_ROUND_EN
    always_comb begin
        result = root_q;
        if ((rem_q > REM_W'(root_q)) && (root_q != '1))
            result = root_q + 8'd1;
    end
`else
    assign result = root_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q   <= '0;
            rem_q  <= '0;
            root_q <= '0;
            iter_q <= '0;
            Ack    <= 1'b0;
        end else begin
            Ack <= (next_state == DONE);
            case (state)
                RD_HI: op_q[15:8] <= MemRdData;
                RD_LO: begin
                    op_q[7:0] <= MemRdData;
                    rem_q     <= '0;
                    root_q    <= '0;
                    iter_q    <= '0;
                end
                CALC: begin
                    rem_q  <= rem_nxt;
                    root_q <= root_nxt;
                    op_q   <= {op_q[13:0], 2'b00};
                    iter_q <= iter_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Memory strobes are forced quiet while Reset is high so an aborted run
    // can never complete its write on the reset edge.
    always_comb begin
        next_state = state;
        MemAddr    = '0;
        MemWrEn    = 1'b0;
        MemWrData  = '0;
        case (state)
            IDLE:  if (Start) next_state = ARMED;
            ARMED: if (!Start) next_state = RD_HI;
            RD_HI: begin
                MemAddr    = AW'(ADDR_HI);
                next_state = RD_LO;
            end
            RD_LO: begin
                MemAddr    = AW'(ADDR_LO);
                next_state = CALC;
            end
            CALC:  if (last_iter) next_state = WR;
            WR: begin
                MemAddr    = AW'(ADDR_RES);
                MemWrData  = result;
                MemWrEn    = 1'b1;
                next_state = DONE;
            end
            DONE:  if (Start) next_state = ARMED;
            default: next_state = IDLE;
        endcase
        if (Reset) begin
            MemAddr   = '0;
            MemWrEn   = 1'b0;
            MemWrData = '0;
        end
    end

endmodule
